// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared AXI4 encodings and the read-master state type. The write master
// reuses the burst/size/cache/response codes defined here.
// Contents:
//   BURST_*  : AxBURST codes
//   SIZE_8B  : AxSIZE code for 8-byte beats
//   CACHE_*  : AxCACHE attribute used for DDR traffic
//   RESP_*   : xRESP codes
//   rd_state_e : read-master FSM states
// -----------------------------------------------------------------------------
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_8B     = 3'b011;

  // Normal non-cacheable bufferable memory.
  localparam logic [3:0] CACHE_NORM_BUF = 4'b0011;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2,
    RD_DONE = 2'd3
  } rd_state_e;

endpackage

// File: rtl/axi_master_rd_if.sv
// -----------------------------------------------------------------------------
// axi_master_rd_if
// AXI4 read address (AR) and read data (R) channels between the read master
// and the MIG/DDR3 slave.
// Modports:
//   master : drives AR payload/arvalid and rready; receives arready and R
//   slave  : the mirror image
// -----------------------------------------------------------------------------
interface axi_master_rd_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 64
);

  // Read address channel
  logic [3:0]        arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arqos;
  logic              arvalid;
  logic              arready;

  // Read data channel
  logic [3:0]        rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/axi_master_rd.sv
// -----------------------------------------------------------------------------
// axi_master_rd
// AXI4 read master serving the read-request side of the DDR3 AXI controller.
// One request produces one INCR burst; returned beats are registered and
// presented as a data/valid pair that writes the read FIFO directly.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   rd_start/addr/len   : controller request (sampled only while rd_ready)
//   rd_ready            : idle, request can be accepted
//   reading, rd_data    : one returned beat, one cycle after the R handshake
//   rd_done, rd_err     : end-of-burst pulse, error flag for the burst
//   m_axi               : AR/R channels toward the slave (master modport)
// 2**ARSIZE_VAL must equal DATA_W/8.
// -----------------------------------------------------------------------------
module axi_master_rd
  import axi_pkg::*;
#(
  parameter logic [3:0] AXI_ID     = 4'h0,
  parameter int         ADDR_W     = 30,
  parameter int         DATA_W     = 64,
  parameter logic [2:0] ARSIZE_VAL = SIZE_8B
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_len,
  output logic              rd_ready,
  output logic              reading,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_done,
  output logic              rd_err,
  axi_master_rd_if.master   m_axi
);

  // Beat-aligned start address: the low three byte-offset bits are dropped.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(7);

  rd_state_e         r_state;
  rd_state_e         w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len;
  logic [7:0]        r_beat_cnt;
  logic              r_err_flag;
  logic              r_reading;
  logic [DATA_W-1:0] r_rd_data;

  logic              w_arvalid;
  logic              w_rready;
  logic              w_accept;
  logic              w_beat;
  logic              w_beat_err;

  // Fixed AR attributes; payload comes from the request latch.
  assign m_axi.arid    = AXI_ID;
  assign m_axi.araddr  = r_addr;
  assign m_axi.arlen   = r_len;
  assign m_axi.arsize  = ARSIZE_VAL;
  assign m_axi.arburst = BURST_INCR;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = CACHE_NORM_BUF;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arqos   = 4'b0000;
  assign m_axi.arvalid = w_arvalid;
  assign m_axi.rready  = w_rready;

  assign reading = r_reading;
  assign rd_data = r_rd_data;

  assign w_accept = (r_state == RD_IDLE) && rd_start;
  assign w_beat   = w_rready && m_axi.rvalid;

  // A beat is bad on a non-OKAY response, a foreign ID, or when rlast and
  // the beat counter disagree about where the burst ends (early or late).
  assign w_beat_err = (m_axi.rresp != RESP_OKAY)
                   || (m_axi.rid != AXI_ID)
                   || ( m_axi.rlast && (r_beat_cnt != r_len))
                   || (!m_axi.rlast && (r_beat_cnt == r_len));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RD_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next    = r_state;
    rd_ready  = 1'b0;
    w_arvalid = 1'b0;
    w_rready  = 1'b0;
    rd_done   = 1'b0;
    rd_err    = 1'b0;
    unique case (r_state)
      RD_IDLE: begin
        rd_ready = 1'b1;
        if (rd_start) w_next = RD_ADDR;
      end
      RD_ADDR: begin
        w_arvalid = 1'b1;
        if (m_axi.arready) w_next = RD_DATA;
      end
      RD_DATA: begin
        w_rready = 1'b1;
        // A late rlast keeps us here; the surplus beats are still forwarded.
        if (m_axi.rvalid && m_axi.rlast) w_next = RD_DONE;
      end
      RD_DONE: begin
        // Coincides with the registered last beat on reading/rd_data.
        rd_done = 1'b1;
        rd_err  = r_err_flag;
        w_next  = RD_IDLE;
      end
      default: w_next = RD_IDLE;
    endcase
  end

  // Request latch, beat counter, error accumulator and the FIFO-facing
  // output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_len      <= '0;
      r_beat_cnt <= '0;
      r_err_flag <= 1'b0;
      r_reading  <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_reading <= w_beat;
      if (w_beat) r_rd_data <= m_axi.rdata;

      if (w_accept) begin
        r_addr     <= rd_addr & ALIGN_MASK;
        r_len      <= rd_len;
        r_beat_cnt <= '0;
        r_err_flag <= 1'b0;
      end else if (w_beat) begin
        // 8-bit wrap is intended: only equality with r_len matters, so a
        // 256-beat burst works.
        r_beat_cnt <= r_beat_cnt + 8'd1;
        if (w_beat_err) r_err_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_master_rd.sv
// -----------------------------------------------------------------------------
// tb_axi_master_rd
// Directed bench for axi_master_rd. A task-driven slave answers each burst,
// a negedge monitor collects reading/rd_data beats and rd_done pulses, and
// each scenario task compares against hand-derived values.
// -----------------------------------------------------------------------------
module tb_axi_master_rd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_start;
  logic [29:0] rd_addr;
  logic [7:0]  rd_len;
  logic        rd_ready;
  logic        reading;
  logic [63:0] rd_data;
  logic        rd_done;
  logic        rd_err;

  axi_master_rd_if #(.ADDR_W(30), .DATA_W(64)) axi ();

  axi_master_rd #(
    .AXI_ID    (4'h0),
    .ADDR_W    (30),
    .DATA_W    (64),
    .ARSIZE_VAL(3'b011)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_start(rd_start),
    .rd_addr (rd_addr),
    .rd_len  (rd_len),
    .rd_ready(rd_ready),
    .reading (reading),
    .rd_data (rd_data),
    .rd_done (rd_done),
    .rd_err  (rd_err),
    .m_axi   (axi)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;

  // Slave-side capture of the AR phase of the most recent burst.
  logic [29:0] cap_addr;
  logic [7:0]  cap_len;
  logic [2:0]  cap_size;
  logic [1:0]  cap_burst;
  int          ar_cycles;
  bit          ar_stable;
  bit          ar_dropped;

  logic [31:0] tag;
  logic [63:0] exp_q[$];
  logic [63:0] mon_q[$];
  int          done_cnt = 0;
  int          beats_at_done = 0;

  function automatic logic [63:0] pat(input int b);
    return {tag, 32'(b)};
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (reading === 1'b1) mon_q.push_back(rd_data);
      if (rd_done === 1'b1) begin
        done_cnt++;
        beats_at_done = mon_q.size();
      end
    end
  end

  function automatic int sb_mismatch();
    int m = 0;
    if (mon_q.size() != exp_q.size()) m++;
    for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++)
      if (mon_q[i] !== exp_q[i]) m++;
    return m;
  endfunction

  task automatic request(input logic [29:0] a, input logic [7:0] l);
    rd_addr  = a;
    rd_len   = l;
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
  endtask

  // Answers one burst: optional AR wait states, then n_beats R beats with
  // an optional idle cycle between beats, an SLVERR on beat err_idx and
  // rlast on beat last_idx. Returns on the negedge after the final beat.
  task automatic slave_burst(input int n_beats, input int ar_wait, input bit gap,
                             input int err_idx, input int last_idx);
    int t = 0;
    int b = 0;
    int guard = 0;
    bit idle_ph = 1'b0;
    bit sent;
    while (axi.arvalid !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (axi.arvalid !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL ar_timeout: arvalid=%b required 1", axi.arvalid);
      return;
    end
    ar_cycles = 0;
    ar_stable = 1'b1;
    cap_addr  = axi.araddr;
    cap_len   = axi.arlen;
    cap_size  = axi.arsize;
    cap_burst = axi.arburst;
    for (int i = 0; i < ar_wait; i++) begin
      axi.arready = 1'b0;
      @(negedge clk);
      ar_cycles++;
      if (axi.arvalid !== 1'b1 || axi.araddr !== cap_addr || axi.arlen !== cap_len)
        ar_stable = 1'b0;
    end
    axi.arready = 1'b1;
    @(negedge clk);
    ar_cycles++;
    axi.arready = 1'b0;
    ar_dropped = (axi.arvalid === 1'b0);
    while (b < n_beats && guard < 1000) begin
      if (gap && idle_ph) begin
        axi.rvalid = 1'b0;
      end else begin
        axi.rvalid = 1'b1;
        axi.rid    = 4'h0;
        axi.rdata  = pat(b);
        axi.rresp  = (b == err_idx) ? 2'b10 : 2'b00;
        axi.rlast  = (b == last_idx);
      end
      if (gap) idle_ph = !idle_ph;
      sent = (axi.rvalid === 1'b1) && (axi.rready === 1'b1);
      @(negedge clk);
      guard++;
      if (sent) begin
        exp_q.push_back(pat(b));
        b++;
      end
    end
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    axi.rresp  = 2'b00;
    if (b < n_beats) begin
      n_vec++; n_err++;
      $display("FAIL r_timeout: beats accepted %0d required %0d", b, n_beats);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_vec++; if (rd_ready !== 1'b1) begin n_err++; $display("FAIL rst_rd_ready: got %b want 1", rd_ready); end
    n_vec++; if (axi.arvalid !== 1'b0) begin n_err++; $display("FAIL rst_arvalid: got %b want 0", axi.arvalid); end
    n_vec++; if (axi.rready !== 1'b0) begin n_err++; $display("FAIL rst_rready: got %b want 0", axi.rready); end
    n_vec++; if (reading !== 1'b0) begin n_err++; $display("FAIL rst_reading: got %b want 0", reading); end
    n_vec++; if (rd_data !== 64'h0) begin n_err++; $display("FAIL rst_rd_data: got %h want 0", rd_data); end
    n_vec++; if (rd_done !== 1'b0 || rd_err !== 1'b0) begin n_err++; $display("FAIL rst_done_err: got %b%b want 00", rd_done, rd_err); end
    n_vec++; if (axi.araddr !== 30'h0 || axi.arlen !== 8'h0) begin n_err++; $display("FAIL rst_ar_latch: got %h/%h want 0/0", axi.araddr, axi.arlen); end
    n_vec++; if (axi.arid !== 4'h0 || axi.arlock !== 1'b0 || axi.arprot !== 3'b000 || axi.arqos !== 4'h0)
      begin n_err++; $display("FAIL rst_ar_zero_attrs: got id=%h lock=%b prot=%h qos=%h want 0", axi.arid, axi.arlock, axi.arprot, axi.arqos); end
    n_vec++; if (axi.arcache !== 4'b0011) begin n_err++; $display("FAIL rst_arcache: got %b want 0011", axi.arcache); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (rd_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", rd_ready); end
  endtask

  task automatic test_single();
    int d0 = done_cnt;
    tag = 32'h1111_0000;
    n_vec++; if (rd_ready !== 1'b1) begin n_err++; $display("FAIL single_ready_pre: got %b want 1", rd_ready); end
    request(30'h100, 8'd7);
    n_vec++; if (rd_ready !== 1'b0 || axi.arvalid !== 1'b1) begin n_err++; $display("FAIL single_addr_phase: ready=%b arvalid=%b want 0 1", rd_ready, axi.arvalid); end
    slave_burst(8, 0, 1'b0, -1, 7);
    n_vec++; if (cap_addr !== 30'h100) begin n_err++; $display("FAIL single_araddr: got %h want 100", cap_addr); end
    n_vec++; if (cap_len !== 8'd7) begin n_err++; $display("FAIL single_arlen: got %0d want 7", cap_len); end
    n_vec++; if (cap_size !== 3'd3 || cap_burst !== 2'd1) begin n_err++; $display("FAIL single_size_burst: got %0d/%0d want 3/1", cap_size, cap_burst); end
    n_vec++; if (ar_cycles !== 1 || !ar_dropped) begin n_err++; $display("FAIL single_ar_cycles: got %0d dropped=%b want 1 1", ar_cycles, ar_dropped); end
    n_vec++; if (rd_done !== 1'b1 || reading !== 1'b1 || rd_err !== 1'b0)
      begin n_err++; $display("FAIL single_done: done=%b reading=%b err=%b want 1 1 0", rd_done, reading, rd_err); end
    n_vec++; if (rd_data !== pat(7)) begin n_err++; $display("FAIL single_last_data: got %h want %h", rd_data, pat(7)); end
    @(negedge clk); #1;
    n_vec++; if (rd_ready !== 1'b1 || rd_done !== 1'b0 || reading !== 1'b0)
      begin n_err++; $display("FAIL single_after: ready=%b done=%b reading=%b want 1 0 0", rd_ready, rd_done, reading); end
    n_vec++; if (sb_mismatch() !== 0) begin n_err++; $display("FAIL single_data: %0d bad beats, got %0d want %0d", sb_mismatch(), mon_q.size(), exp_q.size()); end
    n_vec++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_stalls();
    int d0 = done_cnt;
    tag = 32'h2222_0000;
    request(30'h180, 8'd7);
    slave_burst(8, 5, 1'b1, -1, 7);
    n_vec++; if (!ar_stable || ar_cycles !== 6) begin n_err++; $display("FAIL stall_ar_hold: stable=%b cycles=%0d want 1 6", ar_stable, ar_cycles); end
    n_vec++; if (cap_addr !== 30'h180) begin n_err++; $display("FAIL stall_araddr: got %h want 180", cap_addr); end
    n_vec++; if (rd_done !== 1'b1 || rd_err !== 1'b0) begin n_err++; $display("FAIL stall_done: done=%b err=%b want 1 0", rd_done, rd_err); end
    @(negedge clk); #1;
    n_vec++; if (beats_at_done !== exp_q.size()) begin n_err++; $display("FAIL stall_done_position: beats at done %0d want %0d", beats_at_done, exp_q.size()); end
    n_vec++; if (sb_mismatch() !== 0) begin n_err++; $display("FAIL stall_data: %0d bad beats", sb_mismatch()); end
    n_vec++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL stall_done_cnt: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_max_len();
    int d0 = done_cnt;
    tag = 32'h3333_0000;
    request(30'h107, 8'd255);
    slave_burst(256, 0, 1'b0, -1, 255);
    n_vec++; if (cap_addr !== 30'h100) begin n_err++; $display("FAIL max_araddr: got %h want 100", cap_addr); end
    n_vec++; if (cap_len !== 8'd255) begin n_err++; $display("FAIL max_arlen: got %0d want 255", cap_len); end
    n_vec++; if (rd_done !== 1'b1 || rd_err !== 1'b0) begin n_err++; $display("FAIL max_done: done=%b err=%b want 1 0", rd_done, rd_err); end
    @(negedge clk); #1;
    n_vec++; if (sb_mismatch() !== 0) begin n_err++; $display("FAIL max_data: %0d bad beats", sb_mismatch()); end
    n_vec++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL max_done_cnt: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_errors();
    tag = 32'h4444_0000;
    request(30'h200, 8'd7);
    slave_burst(8, 0, 1'b0, 2, 7);
    n_vec++; if (rd_done !== 1'b1 || rd_err !== 1'b1) begin n_err++; $display("FAIL resp_err: done=%b err=%b want 1 1", rd_done, rd_err); end
    @(negedge clk);
    n_vec++; if (rd_err !== 1'b0) begin n_err++; $display("FAIL resp_err_pulse: got %b want 0", rd_err); end
    tag = 32'h5555_0000;
    request(30'h240, 8'd7);
    slave_burst(5, 0, 1'b0, -1, 4);
    n_vec++; if (rd_done !== 1'b1 || rd_err !== 1'b1) begin n_err++; $display("FAIL early_last: done=%b err=%b want 1 1", rd_done, rd_err); end
    n_vec++; if (reading !== 1'b1 || rd_data !== pat(4)) begin n_err++; $display("FAIL early_last_data: reading=%b data=%h want 1 %h", reading, rd_data, pat(4)); end
    @(negedge clk); #1;
    n_vec++; if (rd_ready !== 1'b1) begin n_err++; $display("FAIL early_last_idle: got %b want 1", rd_ready); end
    n_vec++; if (sb_mismatch() !== 0) begin n_err++; $display("FAIL err_data: %0d bad beats", sb_mismatch()); end
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    tag = 32'h6666_0000;
    rd_addr = 30'h300; rd_len = 8'd3; rd_start = 1'b1;
    @(negedge clk);
    n_vec++; if (rd_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_drop: got %b want 0", rd_ready); end
    rd_addr = 30'h340; rd_len = 8'd1;
    slave_burst(4, 0, 1'b0, -1, 3);
    n_vec++; if (cap_addr !== 30'h300 || cap_len !== 8'd3) begin n_err++; $display("FAIL b2b_first_ar: got %h/%0d want 300/3", cap_addr, cap_len); end
    n_vec++; if (rd_done !== 1'b1) begin n_err++; $display("FAIL b2b_first_done: got %b want 1", rd_done); end
    @(negedge clk);
    n_vec++; if (rd_ready !== 1'b1 || axi.arvalid !== 1'b0) begin n_err++; $display("FAIL b2b_idle: ready=%b arvalid=%b want 1 0", rd_ready, axi.arvalid); end
    @(negedge clk);
    n_vec++; if (axi.arvalid !== 1'b1 || rd_ready !== 1'b0) begin n_err++; $display("FAIL b2b_second_start: arvalid=%b ready=%b want 1 0", axi.arvalid, rd_ready); end
    rd_start = 1'b0;
    tag = 32'h7777_0000;
    slave_burst(2, 0, 1'b0, -1, 1);
    n_vec++; if (cap_addr !== 30'h340 || cap_len !== 8'd1) begin n_err++; $display("FAIL b2b_second_ar: got %h/%0d want 340/1", cap_addr, cap_len); end
    n_vec++; if (rd_done !== 1'b1 || rd_err !== 1'b0) begin n_err++; $display("FAIL b2b_second_done: done=%b err=%b want 1 0", rd_done, rd_err); end
    @(negedge clk); #1;
    n_vec++; if (sb_mismatch() !== 0) begin n_err++; $display("FAIL b2b_data: %0d bad beats", sb_mismatch()); end
    n_vec++; if (done_cnt - d0 !== 2) begin n_err++; $display("FAIL b2b_done_cnt: got %0d want 2", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int d0 = done_cnt;
    tag = 32'h8888_0000;
    request(30'h400, 8'd7);
    slave_burst(2, 0, 1'b0, -1, -1);
    n_vec++; if (reading !== 1'b1 || axi.rready !== 1'b1) begin n_err++; $display("FAIL rmid_pre: reading=%b rready=%b want 1 1", reading, axi.rready); end
    axi.rvalid = 1'b1; axi.rdata = pat(2); axi.rlast = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (axi.arvalid !== 1'b0 || axi.rready !== 1'b0) begin n_err++; $display("FAIL rmid_bus: arvalid=%b rready=%b want 0 0", axi.arvalid, axi.rready); end
    n_vec++; if (reading !== 1'b0 || rd_done !== 1'b0 || rd_data !== 64'h0) begin n_err++; $display("FAIL rmid_out: reading=%b done=%b data=%h want 0 0 0", reading, rd_done, rd_data); end
    axi.rvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (rd_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready: got %b want 1", rd_ready); end
    tag = 32'h9999_0000;
    request(30'h480, 8'd3);
    slave_burst(4, 0, 1'b0, -1, 3);
    n_vec++; if (rd_done !== 1'b1 || rd_err !== 1'b0 || cap_addr !== 30'h480) begin n_err++; $display("FAIL rmid_next: done=%b err=%b addr=%h want 1 0 480", rd_done, rd_err, cap_addr); end
    @(negedge clk); #1;
    n_vec++; if (sb_mismatch() !== 0) begin n_err++; $display("FAIL rmid_data: %0d bad beats", sb_mismatch()); end
    n_vec++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL rmid_done_cnt: got %0d want 1", done_cnt - d0); end
  endtask

  initial begin
    rd_start    = 1'b0;
    rd_addr     = '0;
    rd_len      = '0;
    axi.arready = 1'b0;
    axi.rid     = 4'h0;
    axi.rdata   = '0;
    axi.rresp   = 2'b00;
    axi.rlast   = 1'b0;
    axi.rvalid  = 1'b0;
    tag         = '0;
    test_reset();
    test_single();
    test_stalls();
    test_max_len();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_master_rd.md
Name: axi_master_rd

Overview:
- AXI4 read master: the responder to the read-request side of the DDR3 AXI controller.
- Accepts a start/address/length request from the controller, issues one AXI4 INCR read burst to the MIG/DDR3 slave, and streams returned beats back as a registered data/valid pair that drives the read-FIFO write port directly.
- Signals completion with a one-cycle done pulse so the controller can advance its read address.

Parameters:
- AXI_ID, 4'h0, constant ARID; RID is checked against it.
- ADDR_W, 30, byte address width of araddr and rd_addr.
- DATA_W, 64, data width of rdata and rd_data.
- ARSIZE_VAL, 3'b011, beat size code (8 bytes); must satisfy 2^ARSIZE_VAL == DATA_W/8.

Ports:
- clk  in  1  AXI clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_start  in  1  controller request; level, sampled only while rd_ready=1.
- rd_addr  in  ADDR_W  burst start byte address; bits [2:0] are ignored.
- rd_len  in  8  AXI burst length minus 1 (beats = rd_len+1).
- rd_ready  out  1  master idle and able to accept a request.
- reading  out  1  rd_data holds a valid beat this cycle (FIFO write enable).
- rd_data  out  DATA_W  returned beat.
- rd_done  out  1  one-cycle pulse at end of burst.
- rd_err  out  1  one-cycle pulse coincident with rd_done if any beat had an error.
- m_axi_arid  out  4  =AXI_ID.
- m_axi_araddr  out  ADDR_W  latched address with [2:0] forced to 0.
- m_axi_arlen  out  8  latched rd_len.
- m_axi_arsize  out  3  =ARSIZE_VAL.
- m_axi_arburst  out  2  =2'b01 (INCR).
- m_axi_arlock  out  1  =0.
- m_axi_arcache  out  4  =4'b0011.
- m_axi_arprot  out  3  =0.
- m_axi_arqos  out  4  =0.
- m_axi_arvalid  out  1  address valid.
- m_axi_arready  in  1  slave address ready.
- m_axi_rid  in  4  read ID.
- m_axi_rdata  in  DATA_W  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rlast  in  1  last beat.
- m_axi_rvalid  in  1  read valid.
- m_axi_rready  out  1  master data ready.

Behaviour:
- Reset values (async assertion, applied immediately): state=IDLE, rd_ready=1, arvalid=0, rready=0, reading=0, rd_data=0, rd_done=0, rd_err=0, latched addr/len=0, beat_cnt=0, err_flag=0.
- State machine, encoded one-hot or binary:
  - IDLE: rd_ready=1. If rd_start=1, latch rd_addr and rd_len, clear beat_cnt and err_flag, go to ADDR. rd_ready drops on the next cycle.
  - ADDR: arvalid=1, held with araddr/arlen stable until arvalid&arready. On handshake, go to DATA; arvalid=0 next cycle. Zero-cycle wait is allowed when arready is already high, giving exactly one cycle in ADDR.
  - DATA: rready=1. Each rvalid&rready beat: rd_data<=rdata and reading<=1 on the next cycle (1-cycle registered latency); beat_cnt++. reading=0 in all cycles without a beat.
  - Per-beat error check: err_flag is set if rresp!=2'b00, or rid!=AXI_ID, or (rlast=1 and beat_cnt!=len), or (beat_cnt==len and rlast=0).
  - On the beat with rlast=1, go to DONE.
  - DONE: exactly one cycle. rd_done=1, rd_err=err_flag (this is the same cycle as reading for the last beat). rready=0. Next state is IDLE.
- rd_start is ignored outside IDLE. If rd_start is still high on return to IDLE, a new burst is accepted; the controller is responsible for dropping it.
- beat_cnt is 8 bits and wraps freely. It is compared only against the latched len, so a 256-beat burst (len=255) is legal.
- A beat that arrives with rlast=0 after beat_cnt==len is still forwarded; the master stays in DATA until rlast (error flagged). A late rlast is tolerated this way.
- 4 KB boundary splitting is not done. The caller guarantees bursts do not cross 4 KB.
- Reset mid-burst: everything returns to reset values asynchronously. No done pulse; outstanding slave beats are the system's responsibility, since the slave resets on the same rst_n.
- No backpressure toward the FIFO: rready is constant in DATA. The controller only starts a burst when the FIFO has room for it.

Decomposition:
- Shared package axi_pkg: AXI burst/size/cache/resp encodings (BURST_INCR, SIZE_8B, RESP_OKAY) and the state enum for the read master.
- No sub-module. The address-channel latch and the data-channel pipeline register stay inline. A future axi_master_wr reuses axi_pkg.

Test Plan:
- Single burst: rd_len=7, rd_addr=0x100, arready=1, rvalid every cycle → araddr=0x100, arlen=7, arsize=3, arburst=1; 8 reading pulses with data matching rdata delayed 1 cycle; rd_done one cycle with last beat; rd_ready high the following cycle.
- Stalls: arready low for 5 cycles, rvalid toggling 1/0 → arvalid held with araddr stable; reading count=8; rd_done only after the 8th beat.
- Unaligned address and max length: rd_addr=0x107, rd_len=255 → araddr=0x100; 256 beats; rd_done with rd_err=0.
- Errors: rresp=2'b10 on beat 3 → rd_err=1 with rd_done. Separately, rlast on beat 5 of an 8-beat burst → rd_done after beat 5 with rd_err=1.
- Back-to-back: rd_start held high through the burst → start ignored until IDLE; second burst begins the cycle after rd_ready returns; no beat lost.
- Reset mid-burst: rst_n low during DATA beat 2 → arvalid/rready/reading/rd_done=0 immediately; rd_ready=1 after release; next burst completes normally.
